// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: substitutes BYTES_PER_CYCLE bytes of a
// 128-bit state per clock through combinational inverse S-box lanes.
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_GROUPS = 16 / BYTES_PER_CYCLE;
    localparam int CW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
            $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [127:0]    work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        int base;
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        base    = 0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int b = 0; b < BYTES_PER_CYCLE; b++) begin
                    base = 127 - 8 * (int'(cnt_q) * BYTES_PER_CYCLE + b);
                    work_d[base -: 8] = inv_sbox(work_q[base -: 8]);
                end
                // The counter holds on the last group so it never wraps mid-block.
                if (cnt_q == CW'(NUM_GROUPS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboard bench for inv_sub_bytes_seq: a driver pushes expected results from a
// table-based AES model, a negedge monitor pops and compares them as blocks complete.
module tb_inv_sub_bytes_seq;

    parameter int BYTES_PER_CYCLE = 4;
    localparam int NG = 16 / BYTES_PER_CYCLE;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BYTES_PER_CYCLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    logic [127:0] expQ[$];
    int           acceptQ[$];

    logic [7:0] sboxTab[256];
    logic [7:0] invTab[256];
    int         expTab[256];
    int         logTab[256];

    bit randReady = 0;
    bit prevValid = 0;
    bit hsPrev    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Random backpressure is applied shortly after the edge so the negedge monitor sees a settled value.
    always @(posedge clk) begin
        if (randReady) begin
            #2;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box from exp/log tables over generator 3, then the inverse table by lookup inversion.
    task automatic buildTables();
        int p;
        int inv;
        logic [7:0] b;
        p = 1;
        for (int i = 0; i < 255; i++) begin
            expTab[i] = p;
            logTab[p] = i;
            p = p ^ (((p << 1) ^ (((p >> 7) & 1) * 'h11b)) & 'hff);
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 0 : expTab[(255 - logTab[x]) % 255];
            b = inv[7:0];
            sboxTab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) invTab[sboxTab[x]] = x[7:0];
    endtask

    function automatic logic [127:0] refModel(input logic [127:0] st);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = invTab[st[127 - 8*i -: 8]];
        return r;
    endfunction

    task automatic applyStimulus(input logic [127:0] st, input logic [127:0] exp, input bit expectOut);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = st;
        while (!in_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {127'd0, in_ready}, 128'd1);
            in_valid = 1'b0;
            return;
        end
        if (expectOut) begin
            expQ.push_back(exp);
            acceptQ.push_back(cycle + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compare each completed block on the rising edge of out_valid, and
    // check the block returns to IDLE one cycle after an output handshake.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 0;
            hsPrev    = 0;
        end else begin
            if (hsPrev) begin
                checkOutput("in_ready_after_handshake", {127'd0, in_ready}, 128'd1);
                checkOutput("out_valid_after_handshake", {127'd0, out_valid}, 128'd0);
            end
            if (out_valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", {127'd0, out_valid}, 128'd0);
                end else begin
                    logic [127:0] e;
                    int t0;
                    e  = expQ.pop_front();
                    t0 = acceptQ.pop_front();
                    checkOutput("out_state", out_state, e);
                    checkOutput("latency", 128'(cycle - t0), 128'(NG));
                end
            end
            hsPrev    = out_valid && out_ready;
            prevValid = out_valid;
        end
    end

    task automatic waitIdle(input string name);
        int w;
        w = 0;
        while ((expQ.size() != 0 || !in_ready) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        checkOutput(name, 128'(expQ.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] st;
        logic [127:0] bpExp;
        int w;
        int waitCycles;

        buildTables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("reset_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset_out_state", out_state, 128'd0);
        checkOutput("reset_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;

        applyStimulus({16{8'h63}}, 128'd0, 1);
        checkOutput("run_busy", {127'd0, busy}, 128'd1);
        checkOutput("run_in_ready", {127'd0, in_ready}, 128'd0);
        applyStimulus(128'h637c777bf26b6fc53001672bfed7ab76,
                      128'h000102030405060708090a0b0c0d0e0f, 1);
        applyStimulus({16{8'hed}}, {16{8'h53}}, 1);
        applyStimulus({16{8'h16}}, {16{8'hff}}, 1);

        for (int x = 0; x < 256; x++) begin
            applyStimulus({16{sboxTab[x]}}, {16{x[7:0]}}, 1);
        end
        waitIdle("drain_roundtrip");

        randReady = 1;
        for (int n = 0; n < 40; n++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(st, refModel(st), 1);
        end
        waitIdle("drain_random");
        randReady = 0;
        @(negedge clk);
        out_ready = 1'b1;
        waitIdle("drain_before_bp");

        out_ready = 1'b0;
        st    = {$urandom, $urandom, $urandom, $urandom};
        bpExp = refModel(st);
        applyStimulus(st, bpExp, 1);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_out_valid_rise", {127'd0, out_valid}, 128'd1);
        in_valid = 1'b1;
        in_state = ~st;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("bp_out_state", out_state, bpExp);
            checkOutput("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("bp_release_out_valid", {127'd0, out_valid}, 128'd0);

        st = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(st, refModel(st), 0);
        waitCycles = (NG >= 2) ? 1 : 0;
        repeat (waitCycles) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_out_state", out_state, 128'd0);
        checkOutput("midreset_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("midreset_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("midreset_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;
        repeat (NG + 3) begin
            @(negedge clk);
            checkOutput("midreset_no_output", {127'd0, out_valid}, 128'd0);
        end
        st = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(st, refModel(st), 1);
        applyStimulus(128'h637c777bf26b6fc53001672bfed7ab76,
                      128'h000102030405060708090a0b0c0d0e0f, 1);
        waitIdle("drain_final");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Sequential InvSubBytes engine for the AES-256 decryption datapath. It is the inverse of the forward S-box substitution used in encryption. It accepts one 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to BYTES_PER_CYCLE bytes per clock. It returns the substituted state over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decryption round loop.

Parameters:
BYTES_PER_CYCLE, 4, inverse S-box lanes instantiated; legal values 1, 2, 4, 8, 16; any other value is a compile-time error
NUM_GROUPS, 16/BYTES_PER_CYCLE (localparam), processing cycles per block

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state
in_state  input  128  state to substitute; byte i = in_state[127-8i -: 8], byte 0 = MSB
out_valid  output  1  out_state holds the completed result
out_ready  input  1  downstream accepts the result
out_state  output  128  substituted state, same byte order as in_state
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (sampled on clk when rst=1): FSM goes to IDLE. Working register is cleared, group counter is cleared. Outputs: in_ready=1 (combinational from IDLE), out_valid=0, out_state=0, busy=0.
- rst mid-operation aborts the block in flight. The data is discarded and never presented.
- Inverse S-box lanes are purely combinational inside this block. Each lane is a 256-entry table or a GF(2^8) inverse plus inverse affine. inv_sbox(sbox(x)) = x for all x.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge T, load the working register with in_state, set cnt=0, go to RUN.
  - RUN: in_ready=0, busy=1. Each edge replaces bytes cnt*B .. cnt*B+B-1 of the working register with their inverse S-box values (B = BYTES_PER_CYCLE), then cnt increments. When cnt==NUM_GROUPS-1 the FSM goes to DONE on that edge. in_valid is ignored.
  - DONE: out_valid=1, busy=1. The working register is frozen. On out_valid&&out_ready the FSM goes to IDLE at that edge.
- Latency: out_valid rises after edge T+NUM_GROUPS (4 edges for B=4, 16 for B=1, 1 for B=16).
- Throughput: in_ready returns the cycle after the output handshake. There is no same-cycle accept on output completion, so one block takes NUM_GROUPS+2 cycles minimum.
- out_state is the working register at all times. It is defined as the result only while out_valid=1, and it holds stable while out_valid=1 && out_ready=0 (backpressure of any length).
- out_ready asserted while out_valid=0 has no effect.
- Byte processing order: group 0 = bytes 0..B-1 (MSB end) first. No byte is substituted twice.
- The counter width is ceil(log2(NUM_GROUPS)), minimum 1 bit. The counter never wraps within a block and is reset to 0 on each accept.

Test Plan:
- Reset, then drive in_state=0x6363...63 with in_valid=1 at edge T, out_ready=1 -> out_valid first high after edge T+4 (B=4); out_state=0x0000...00; in_ready=1 one cycle later.
- in_state=0x637c777bf26b6fc53001672bfed7ab76 -> out_state=0x000102030405060708090a0b0c0d0e0f.
- Round trip: for all x in 0..255, feed 16 copies of sbox(x) using the encryption S-box -> every out_state byte equals x (e.g. x=0x53: in 0xed.. -> out 0x53..; x=0xff: in 0x16.. -> out 0xff..).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stay stable, in_ready stays 0, and a new in_valid is not accepted. Release -> IDLE the next cycle.
- Reset mid-block: assert rst in the 2nd RUN cycle -> out_valid never rises for that block, out_state=0, in_ready=1 after the reset edge. A subsequent block completes correctly.
- Parameter sweep B=1, 2, 16 with the same vectors -> results identical; out_valid after exactly 16, 8 and 1 edges respectively.
